pet_needs_engine: RTL and testbench
===================================

PET_NEEDS_ENGINE -- requirements
Module: pet_needs_engine

Interface
REQ-001 Parameter TICK_DIV, default 5000000, clk cycles per decay tick (0.1 s at 50 MHz).
REQ-002 Parameter REFILL_HOLD, default 50000000, consecutive held cycles per refill step.
REQ-003 Parameter REFILL_STEP, default 30, amount added to one need per refill step.
REQ-004 Parameter LIFE_PLUS, default 70; LIFE_MINUS, default 30; DISEASE_TH, default 20.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 run  in  1  1 = pet alive and past start screen; enables decay.
REQ-008 act_sel  in  2  action target: 0 play/fun, 1 eat/food, 2 sleep/rest, 3 heal/all.
REQ-009 act_hold  in  1  action input held (already debounced, active-high).
REQ-010 restore  in  1  one-cycle pulse to restart the pet with full needs.
REQ-011 food, fun, rest, life  out  7 each  need values, 0..100.
REQ-012 disease  out  1  life <= DISEASE_TH.
REQ-013 death  out  1  sticky: life has reached 0.
REQ-014 act_busy  out  1  refill hold in progress (screen animation flag).
REQ-015 step_done  out  1  one-cycle pulse when a refill step is applied.

Function
REQ-016 Prescaler counts 0..TICK_DIV-1 free-running; tick is a one-cycle internal pulse at wrap.
REQ-017 On tick with run=1 and death=0: food, fun, rest each decrement by 1, saturating at 0.
REQ-018 Same tick: life += (count of needs >= LIFE_PLUS) - (count of needs <= LIFE_MINUS), using pre-decrement need values, result clamped to 0..100 in one step.
REQ-019 Tick with run=0 or death=1: all needs and life hold.
REQ-020 Refill FSM states IDLE, HOLD; IDLE->HOLD when act_hold=1 and run=1 and death=0; HOLD->IDLE when act_hold=0, run=0 or death=1.
REQ-021 In HOLD, hold counter increments each cycle; at REFILL_HOLD-1 it returns to 0 and a refill step is applied next edge with step_done=1 for that cycle.
REQ-022 Step for act_sel 0/1/2: target = min(target+REFILL_STEP, 100), arithmetic in 8 bits before clamp.
REQ-023 Step for act_sel 3: food, fun, rest all set to 100; life unchanged.
REQ-024 act_sel change during HOLD: hold counter clears to 0, state stays HOLD.
REQ-025 Refill step and tick on same cycle, same need: refill result wins, decrement dropped; other needs decay normally; life uses REQ-018 on pre-update values.
REQ-026 act_busy = (state == HOLD); hold counter cleared on every exit from HOLD.
REQ-027 disease and death registered: one cycle after life change; death sets when life==0 and clears only by restore or reset.
REQ-028 restore: food, fun, rest, life = 100, death=0, state IDLE, prescaler and hold counter 0; overrides every other update that cycle.

Reset
REQ-029 rst_n=0 at clk edge: food=fun=rest=life=100, disease=0, death=0, act_busy=0, step_done=0, state IDLE, all counters 0.
REQ-030 Reset mid-HOLD abandons the step; no step_done is issued.

Configuration
REQ-031 Macro PET_NEEDS_HEAL_GATE_EN defined: act_sel=3 enters/stays HOLD only when disease=1; disease falling in HOLD returns to IDLE.
REQ-032 Macro undefined: heal accepted regardless of disease.

Structure
REQ-033 Shared package pet_pkg holds NEED_MAX=100, act_sel codes, refill FSM state typedef, default thresholds.
REQ-034 Prescaler is sub-module pet_tick_gen (params DIV; outputs tick); rest is one module.

Verification (bench uses TICK_DIV=10, REFILL_HOLD=20)
REQ-035 Reset, run=1, 10 ticks -> food=fun=rest=90, life=100 (clamped), no disease.
REQ-036 act_sel=1, hold 20 cycles from food=50 -> food=80, one step_done; hold 40 more -> food=100.
REQ-037 Force all needs to 25, life=22, tick -> life=19, disease=1 next cycle; continue -> death=1 at life 0, needs frozen, restore -> all 100, death=0.
REQ-038 Refill step coincident with tick on fun=40 -> fun=70, food/rest decrement by 1.
REQ-039 act_sel=3 with disease=0: PET_NEEDS_HEAL_GATE_EN defined -> act_busy stays 0; undefined -> after 20 cycles all needs 100.
REQ-040 rst_n low at hold count 15 -> no step_done, counters 0, values 100.

Source files
------------

// File: rtl/pet_pkg.sv
// Shared constants, action codes, refill FSM state type and need arithmetic
// helpers for the pet needs engine.
package pet_pkg;

   localparam logic [6:0] NEED_MAX = 7'd100;

   localparam int TICK_DIV_DEF    = 5000000;
   localparam int REFILL_HOLD_DEF = 50000000;
   localparam int REFILL_STEP_DEF = 30;
   localparam int LIFE_PLUS_DEF   = 70;
   localparam int LIFE_MINUS_DEF  = 30;
   localparam int DISEASE_TH_DEF  = 20;

   typedef enum logic [1:0] {
      ACT_PLAY  = 2'd0,
      ACT_EAT   = 2'd1,
      ACT_SLEEP = 2'd2,
      ACT_HEAL  = 2'd3
   } act_sel_t;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } refill_state_t;

   function automatic logic [6:0] need_dec(input logic [6:0] v);
      return (v == 7'd0) ? 7'd0 : v - 7'd1;
   endfunction

   // Sum is formed in 8 bits so values up to 255 clamp correctly to NEED_MAX.
   function automatic logic [6:0] need_add(input logic [6:0] v, input logic [7:0] step);
      logic [7:0] sum;
      sum = {1'b0, v} + step;
      return (sum > {1'b0, NEED_MAX}) ? NEED_MAX : sum[6:0];
   endfunction

   function automatic logic [1:0] count3(input logic a, input logic b, input logic c);
      return {1'b0, a} + {1'b0, b} + {1'b0, c};
   endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the wrap cycle as tick.
module pet_tick_gen #(
   parameter int DIV = 5000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0]  LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/pet_needs_engine.sv
// Virtual pet needs: periodic decay, life balance and a hold-to-refill FSM.
// Optional build macro PET_NEEDS_HEAL_GATE_EN restricts heal to a diseased pet.
module pet_needs_engine
   import pet_pkg::*;
#(
   parameter int TICK_DIV    = TICK_DIV_DEF,
   parameter int REFILL_HOLD = REFILL_HOLD_DEF,
   parameter int REFILL_STEP = REFILL_STEP_DEF,
   parameter int LIFE_PLUS   = LIFE_PLUS_DEF,
   parameter int LIFE_MINUS  = LIFE_MINUS_DEF,
   parameter int DISEASE_TH  = DISEASE_TH_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [1:0] act_sel,
   input  logic       act_hold,
   input  logic       restore,
   output logic [6:0] food,
   output logic [6:0] fun,
   output logic [6:0] rest,
   output logic [6:0] life,
   output logic       disease,
   output logic       death,
   output logic       act_busy,
   output logic       step_done
);

   localparam int            HW        = (REFILL_HOLD > 1) ? $clog2(REFILL_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(REFILL_HOLD - 1);
   localparam logic [7:0]    STEP8     = 8'(REFILL_STEP);
   localparam logic [6:0]    PLUS_TH   = 7'(LIFE_PLUS);
   localparam logic [6:0]    MINUS_TH  = 7'(LIFE_MINUS);
   localparam logic [6:0]    DIS_TH    = 7'(DISEASE_TH);

   logic          tick;
   refill_state_t state;
   logic [HW-1:0] hold_cnt;
   logic [1:0]    sel_q;
   logic          heal_ok;
   logic          hold_ok;
   logic          step_now;
   logic          decay;
   logic [1:0]    n_up;
   logic [1:0]    n_dn;
   logic signed [8:0] life_sum;
   logic [6:0]    food_nx, fun_nx, rest_nx, life_nx;

   pet_tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (restore),
      .tick  (tick)
   );

`ifdef PET_NEEDS_HEAL_GATE_EN
   assign heal_ok = (act_sel != ACT_HEAL) || disease;
`else
   assign heal_ok = 1'b1;
`endif

   assign hold_ok  = act_hold && run && !death && heal_ok;
   assign step_now = (state == HOLD) && hold_ok && (act_sel == sel_q) && (hold_cnt == HOLD_LAST);
   assign decay    = tick && run && !death;
   assign act_busy = (state == HOLD);

   // Life balance always looks at the needs as they were before this edge.
   assign n_up     = count3(food >= PLUS_TH,  fun >= PLUS_TH,  rest >= PLUS_TH);
   assign n_dn     = count3(food <= MINUS_TH, fun <= MINUS_TH, rest <= MINUS_TH);
   assign life_sum = $signed({2'b00, life}) + $signed({7'b0, n_up}) - $signed({7'b0, n_dn});

   // NOTE: every always_comb output is given a default first so no latch is inferred.
   always_comb begin
      food_nx = food;
      fun_nx  = fun;
      rest_nx = rest;
      life_nx = life;
      if (decay) begin
         food_nx = need_dec(food);
         fun_nx  = need_dec(fun);
         rest_nx = need_dec(rest);
         if (life_sum[8])
            life_nx = 7'd0;
         else if (life_sum > $signed({2'b00, NEED_MAX}))
            life_nx = NEED_MAX;
         else
            life_nx = life_sum[6:0];
      end
      // A refill overrides the decrement of the need it targets.
      if (step_now) begin
         case (act_sel)
            ACT_PLAY:  fun_nx  = need_add(fun,  STEP8);
            ACT_EAT:   food_nx = need_add(food, STEP8);
            ACT_SLEEP: rest_nx = need_add(rest, STEP8);
            default: begin
               food_nx = NEED_MAX;
               fun_nx  = NEED_MAX;
               rest_nx = NEED_MAX;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || restore) begin
         food      <= NEED_MAX;
         fun       <= NEED_MAX;
         rest      <= NEED_MAX;
         life      <= NEED_MAX;
         disease   <= 1'b0;
         death     <= 1'b0;
         step_done <= 1'b0;
         state     <= IDLE;
         hold_cnt  <= '0;
         sel_q     <= 2'd0;
      end else begin
         food      <= food_nx;
         fun       <= fun_nx;
         rest      <= rest_nx;
         life      <= life_nx;
         disease   <= (life <= DIS_TH);
         death     <= death || (life == 7'd0);
         step_done <= 1'b0;
         case (state)
            IDLE: begin
               if (hold_ok) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
                  sel_q    <= act_sel;
               end
            end
            HOLD: begin
               if (!hold_ok) begin
                  state    <= IDLE;
                  hold_cnt <= '0;
               end else if (act_sel != sel_q) begin
                  sel_q    <= act_sel;
                  hold_cnt <= '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  hold_cnt  <= '0;
                  step_done <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               hold_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pet_needs_engine.sv
// Self-checking bench for pet_needs_engine against a cycle-level behavioural model.
module tb_pet_needs_engine;

   localparam int TICK_DIV    = 10;
   localparam int REFILL_HOLD = 20;
   localparam int REFILL_STEP = 30;
   localparam int LIFE_PLUS   = 70;
   localparam int LIFE_MINUS  = 30;
   localparam int DISEASE_TH  = 20;

   logic       clk = 1'b0;
   logic       rst_n, run, act_hold, restore;
   logic [1:0] act_sel;
   logic [6:0] food, fun, rest, life;
   logic       disease, death, act_busy, step_done;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: need[0]=food, need[1]=fun, need[2]=rest.
   int m_need[3] = '{100, 100, 100};
   int m_life = 100;
   int m_held = 0;
   int m_sel  = 0;
   int m_div  = 0;
   bit m_dis = 0, m_death = 0, m_busy = 0, m_sd = 0;

   pet_needs_engine #(
      .TICK_DIV(TICK_DIV), .REFILL_HOLD(REFILL_HOLD), .REFILL_STEP(REFILL_STEP),
      .LIFE_PLUS(LIFE_PLUS), .LIFE_MINUS(LIFE_MINUS), .DISEASE_TH(DISEASE_TH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .act_sel(act_sel), .act_hold(act_hold),
      .restore(restore), .food(food), .fun(fun), .rest(rest), .life(life),
      .disease(disease), .death(death), .act_busy(act_busy), .step_done(step_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] dut_vec();
      return {food, fun, rest, life, disease, death, act_busy, step_done};
   endfunction

   function automatic logic [31:0] exp_vec();
      return {7'(m_need[0]), 7'(m_need[1]), 7'(m_need[2]), 7'(m_life), m_dis, m_death, m_busy, m_sd};
   endfunction

   function automatic string show(input logic [31:0] v);
      return $sformatf("food=%0d fun=%0d rest=%0d life=%0d disease=%0b death=%0b busy=%0b step=%0b",
                       v[31:25], v[24:18], v[17:11], v[10:4], v[3], v[2], v[1], v[0]);
   endfunction

   function automatic bit heal_allowed();
`ifdef PET_NEEDS_HEAL_GATE_EN
      return (act_sel != 2'd3) || m_dis;
`else
      return 1'b1;
`endif
   endfunction

   function automatic int target_of(input int sel);
      return (sel == 0) ? 1 : (sel == 1) ? 0 : 2;
   endfunction

   // Applies the rules of the pet to one rising edge using the current inputs.
   task automatic model_edge();
      int  old_need[3];
      int  old_life, up, dn, t;
      bit  tk, keep;
      bit  refilled[3];
      if (!rst_n || restore) begin
         for (int i = 0; i < 3; i++) m_need[i] = 100;
         m_life = 100; m_dis = 0; m_death = 0; m_busy = 0; m_sd = 0;
         m_held = 0; m_div = 0; m_sel = 0;
         return;
      end
      old_need = m_need;
      old_life = m_life;
      refilled = '{0, 0, 0};
      tk    = (m_div == TICK_DIV - 1);
      m_div = tk ? 0 : m_div + 1;
      m_sd  = 0;
      keep  = act_hold && run && !m_death && heal_allowed();
      if (!m_busy) begin
         if (keep) begin m_busy = 1; m_held = 0; m_sel = act_sel; end
      end else if (!keep) begin
         m_busy = 0; m_held = 0;
      end else if (int'(act_sel) != m_sel) begin
         m_sel = act_sel; m_held = 0;
      end else if (m_held == REFILL_HOLD - 1) begin
         m_held = 0;
         m_sd   = 1;
         if (act_sel == 2'd3) begin
            for (int i = 0; i < 3; i++) begin m_need[i] = 100; refilled[i] = 1; end
         end else begin
            t = target_of(act_sel);
            m_need[t] = (m_need[t] + REFILL_STEP > 100) ? 100 : m_need[t] + REFILL_STEP;
            refilled[t] = 1;
         end
      end else begin
         m_held++;
      end
      if (tk && run && !m_death) begin
         up = 0; dn = 0;
         for (int i = 0; i < 3; i++) begin
            if (old_need[i] >= LIFE_PLUS)  up++;
            if (old_need[i] <= LIFE_MINUS) dn++;
            if (!refilled[i] && m_need[i] > 0) m_need[i]--;
         end
         m_life = old_life + up - dn;
         if (m_life < 0)   m_life = 0;
         if (m_life > 100) m_life = 100;
      end
      m_dis   = (old_life <= DISEASE_TH);
      m_death = m_death || (old_life == 0);
   endtask

   task automatic clk_step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; run = 1'b0; act_sel = 2'd0; act_hold = 1'b0; restore = 1'b0;
      repeat (3) clk_step();
      n_cmp++;
      if (dut_vec() !== {7'd100, 7'd100, 7'd100, 7'd100, 4'b0000}) begin
         n_bad++;
         $display("FAIL reset_state: got %s want %s", show(dut_vec()), show({7'd100, 7'd100, 7'd100, 7'd100, 4'b0000}));
      end
      rst_n = 1'b1;
   endtask

   task automatic test_decay();
      run = 1'b1;
      for (int c = 0; c < 10 * TICK_DIV; c++) clk_step();
      n_cmp++;
      if ({food, fun, rest, life, disease} !== {7'd90, 7'd90, 7'd90, 7'd100, 1'b0}) begin
         n_bad++;
         $display("FAIL decay_10_ticks: got %s want food=fun=rest=90 life=100 disease=0", show(dut_vec()));
      end
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL decay_model: got %s want %s", show(dut_vec()), show(exp_vec()));
      end
   endtask

   task automatic test_refill();
      int sd_cnt = 0;
      int guard = 0;
      while (m_need[0] != 50 && guard < 1000) begin clk_step(); guard++; end
      n_cmp++;
      if (food !== 7'd50) begin
         n_bad++;
         $display("FAIL refill_setup: food=%0d want 50", food);
      end
      act_sel = 2'd1; act_hold = 1'b1;
      for (int c = 1; c <= 61; c++) begin
         clk_step();
         if (step_done === 1'b1) sd_cnt++;
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL refill_cycle%0d: got %s want %s", c, show(dut_vec()), show(exp_vec()));
         end
         if (c == 21) begin
            n_cmp++;
            if (sd_cnt != 1) begin
               n_bad++;
               $display("FAIL refill_first_step: step_done pulses=%0d want 1", sd_cnt);
            end
         end
      end
      n_cmp++;
      if (sd_cnt != 3 || food !== 7'd100) begin
         n_bad++;
         $display("FAIL refill_saturate: pulses=%0d food=%0d want 3 and 100", sd_cnt, food);
      end
      act_hold = 1'b0;
      clk_step();
      n_cmp++;
      if (act_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL refill_release: act_busy=%0b want 0", act_busy);
      end
   endtask

   task automatic test_coincident();
      int guard = 0;
      int pre_food, pre_rest;
      act_sel = 2'd0;
      while (!(m_need[1] == 42 && m_div == TICK_DIV - 1) && guard < 3000) begin clk_step(); guard++; end
      act_hold = 1'b1;
      repeat (REFILL_HOLD) clk_step();
      pre_food = m_need[0];
      pre_rest = m_need[2];
      n_cmp++;
      if (fun !== 7'd40) begin
         n_bad++;
         $display("FAIL coincident_setup: fun=%0d want 40", fun);
      end
      clk_step();
      n_cmp++;
      if ({fun, step_done} !== {7'd70, 1'b1} || food !== 7'(pre_food - 1) || rest !== 7'(pre_rest - 1)) begin
         n_bad++;
         $display("FAIL coincident_step: got %s want fun=70 food=%0d rest=%0d step=1",
                  show(dut_vec()), pre_food - 1, pre_rest - 1);
      end
      act_hold = 1'b0;
      clk_step();
   endtask

   task automatic test_heal();
      act_sel = 2'd3; act_hold = 1'b1;
      for (int c = 1; c <= REFILL_HOLD + 1; c++) begin
         clk_step();
`ifdef PET_NEEDS_HEAL_GATE_EN
         n_cmp++;
         if (act_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL heal_gated_cycle%0d: act_busy=%0b want 0", c, act_busy);
         end
`endif
      end
`ifndef PET_NEEDS_HEAL_GATE_EN
      n_cmp++;
      if ({food, fun, rest} !== {7'd100, 7'd100, 7'd100}) begin
         n_bad++;
         $display("FAIL heal_all: got %s want food=fun=rest=100", show(dut_vec()));
      end
`endif
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL heal_model: got %s want %s", show(dut_vec()), show(exp_vec()));
      end
      act_hold = 1'b0; act_sel = 2'd0;
      clk_step();
   endtask

   task automatic test_death();
      int  guard = 0;
      bit  seen19 = 0, chk_dis = 0;
      logic [20:0] frozen;
      while (!m_death && guard < 3000) begin
         clk_step();
         guard++;
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL death_run_cycle%0d: got %s want %s", guard, show(dut_vec()), show(exp_vec()));
         end
         if (chk_dis) begin
            chk_dis = 0;
            n_cmp++;
            if (disease !== 1'b1) begin
               n_bad++;
               $display("FAIL disease_rise: disease=%0b want 1 one cycle after life=19", disease);
            end
         end
         if (!seen19 && m_life == 19) begin
            seen19 = 1; chk_dis = 1;
            n_cmp++;
            if ({life, disease} !== {7'd19, 1'b0}) begin
               n_bad++;
               $display("FAIL life_to_19: life=%0d disease=%0b want 19 and 0", life, disease);
            end
         end
      end
      n_cmp++;
      if (guard >= 3000 || death !== 1'b1 || life !== 7'd0) begin
         n_bad++;
         $display("FAIL death_reached: death=%0b life=%0d want 1 and 0", death, life);
      end
      frozen = {food, fun, rest};
      repeat (4 * TICK_DIV) clk_step();
      n_cmp++;
      if ({food, fun, rest, life, death} !== {frozen, 7'd0, 1'b1}) begin
         n_bad++;
         $display("FAIL death_frozen: got %s want frozen food/fun/rest life=0 death=1", show(dut_vec()));
      end
      restore = 1'b1;
      clk_step();
      restore = 1'b0;
      n_cmp++;
      if (dut_vec() !== {7'd100, 7'd100, 7'd100, 7'd100, 4'b0000}) begin
         n_bad++;
         $display("FAIL restore: got %s want all 100 and flags 0", show(dut_vec()));
      end
   endtask

   task automatic test_reset_mid_hold();
      int guard = 0;
      act_sel = 2'd0; act_hold = 1'b1;
      while (!(m_busy && m_held == 15) && guard < 200) begin clk_step(); guard++; end
      rst_n = 1'b0;
      clk_step();
      n_cmp++;
      if (dut_vec() !== {7'd100, 7'd100, 7'd100, 7'd100, 4'b0000}) begin
         n_bad++;
         $display("FAIL reset_mid_hold: got %s want all 100 and flags 0", show(dut_vec()));
      end
      repeat (5) clk_step();
      rst_n = 1'b1;
      act_hold = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         clk_step();
         n_cmp++;
         if (step_done !== 1'b0 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL after_reset_cycle%0d: got %s want %s", c, show(dut_vec()), show(exp_vec()));
         end
      end
      // A fresh hold must need the full count again: the step lands 21 edges later.
      act_hold = 1'b1;
      for (int c = 1; c <= REFILL_HOLD + 1; c++) begin
         clk_step();
         n_cmp++;
         if (step_done !== ((c == REFILL_HOLD + 1) ? 1'b1 : 1'b0)) begin
            n_bad++;
            $display("FAIL rehold_cycle%0d: step_done=%0b", c, step_done);
         end
      end
      act_hold = 1'b0;
      clk_step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 29) == 0) act_hold = ~act_hold;
         if ($urandom_range(0, 39) == 0) act_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0) run = ~run;
         restore = ($urandom_range(0, 299) == 0);
         rst_n   = ($urandom_range(0, 599) != 0);
         clk_step();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL random_cycle%0d: got %s want %s", c, show(dut_vec()), show(exp_vec()));
         end
      end
      restore = 1'b0; rst_n = 1'b1; act_hold = 1'b0;
      clk_step();
   endtask

   initial begin
      test_reset();
      test_decay();
      test_refill();
      test_coincident();
      test_heal();
      test_death();
      test_reset_mid_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
